score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 120 ++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper
//   Tracks the two player scores for the game. Point requests are level
//   inputs; a point event is a rising edge seen against a registered copy.
//   Accepted points bump the score, raise a one-cycle strobe and start a
//   holdoff lockout. The first player to reach WIN_SCORE becomes the winner.
//
// Ports
//   clk          system clock, rising-edge
//   rst_n        asynchronous active-low reset
//   game_state   0 splash (clear), 1 play, 2 end (freeze), 3 unused (freeze)
//   p1_hit       level point request, player 1
//   p2_hit       level point request, player 2
//   p1, p2       registered scores, saturate at WIN_SCORE
//   winner       registered winner code (see table)
//   point_pulse  one-cycle strobe after any accepted point
//
// winner encoding
//   state     | meaning
//   WIN_NONE  | no winner yet, points may be accepted
//   WIN_P1    | player 1 reached WIN_SCORE
//   WIN_P2    | player 2 reached WIN_SCORE
module score_keeper #(
  parameter int unsigned WIN_SCORE = 5,
  parameter int unsigned HOLDOFF   = 1000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] game_state,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [2:0] p1,
  output logic [2:0] p2,
  output logic [1:0] winner,
  output logic       point_pulse
);

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_e;

  localparam logic [2:0]       WIN_C     = 3'(WIN_SCORE);
  localparam logic [CNT_W-1:0] HOLDOFF_C = CNT_W'(HOLDOFF);

  localparam logic [1:0] GS_SPLASH = 2'd0;
  localparam logic [1:0] GS_PLAY   = 2'd1;

  logic [2:0]       p1_q, p1_d;
  logic [2:0]       p2_q, p2_d;
  winner_e          winner_q, winner_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             hit1_q, hit2_q;

  logic ev1, ev2, can_accept, acc1, acc2;

  always_comb begin
    ev1 = p1_hit & ~hit1_q;
    ev2 = p2_hit & ~hit2_q;

    can_accept = (game_state == GS_PLAY) && (hold_q == '0) && (winner_q == WIN_NONE);

    // A simultaneous event from both players is treated as a tie and dropped.
    acc1 = can_accept & ev1 & ~ev2 & (p1_q < WIN_C);
    acc2 = can_accept & ev2 & ~ev1 & (p2_q < WIN_C);

    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    pulse_d  = 1'b0;
    hold_d   = (hold_q != '0) ? hold_q - CNT_W'(1) : '0;

    if (game_state == GS_SPLASH) begin
      p1_d     = '0;
      p2_d     = '0;
      winner_d = WIN_NONE;
      hold_d   = '0;
    end else if (acc1) begin
      p1_d    = p1_q + 3'd1;
      pulse_d = 1'b1;
      hold_d  = HOLDOFF_C;
      if (p1_q + 3'd1 == WIN_C) winner_d = WIN_P1;
    end else if (acc2) begin
      p2_d    = p2_q + 3'd1;
      pulse_d = 1'b1;
      hold_d  = HOLDOFF_C;
      if (p2_q + 3'd1 == WIN_C) winner_d = WIN_P2;
    end
  end

  // Hit copies reset high so a request already asserted out of reset is
  // not mistaken for a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= WIN_NONE;
      pulse_q  <= 1'b0;
      hold_q   <= '0;
      hit1_q   <= 1'b1;
      hit2_q   <= 1'b1;
    end else begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      pulse_q  <= pulse_d;
      hold_q   <= hold_d;
      hit1_q   <= p1_hit;
      hit2_q   <= p2_hit;
    end
  end

  assign p1          = p1_q;
  assign p2          = p2_q;
  assign winner      = winner_q;
  assign point_pulse = pulse_q;

endmodule
